sp_ram_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port RAM (`sp_ram`, registered read, one operation per clock) between requester A and requester B. Sits directly in front of the RAM's `we`/`re`/`addr`/`data_in`/`data_out` pins and drives them from a small registered FSM. Arbitration is round-robin with a fixed-priority build option. Read data is returned with a per-requester valid strobe.

---
 rtl/sp_ram_arbiter.sv | 123 ++++++++++++
 tb/tb_sp_ram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: shares one single-port, registered-read RAM between
// requesters A and B. A registered three-state FSM drives the RAM pins.
// Winner selection is round-robin; defining SP_RAM_ARB_FIXED_PRIO_EN
// gives A fixed priority over B and removes the last-grant pointer.
//
// state | meaning
// IDLE  | waiting for a request; requests are only sampled here
// ISSUE | operation on the RAM pins, RAM executes on the closing edge
// RDRET | read data on rdata, winner's rvalid high
module sp_ram_arbiter #(
  parameter int DATA = 4,
  parameter int ADDR = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [ADDR-1:0] a_addr,
  input  logic [DATA-1:0] a_wdata,
  output logic            a_gnt,
  output logic            a_rvalid,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [ADDR-1:0] b_addr,
  input  logic [DATA-1:0] b_wdata,
  output logic            b_gnt,
  output logic            b_rvalid,
  output logic [DATA-1:0] rdata,
  output logic            ram_we,
  output logic            ram_re,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_din,
  input  logic [DATA-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDRET = 2'd2
  } state_t;

  state_t state;
  logic   pick_a;

  assign rdata = ram_dout;

`ifdef SP_RAM_ARB_FIXED_PRIO_EN
  // A wins whenever it requests; B only gets the RAM when A is quiet.
  assign pick_a = a_req;
`else
  logic last_b;

  assign pick_a = a_req & (~b_req | last_b);

  // Remember who was granted last; reset to B so A wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (state == IDLE && (a_req || b_req)) begin
      last_b <= ~pick_a;
    end
  end
`endif

  // Sequencing FSM with registered grant, strobe and rvalid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      ram_we   <= 1'b0;
      ram_re   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            state <= ISSUE;
            a_gnt <= pick_a;
            b_gnt <= ~pick_a;
            if (pick_a) begin
              ram_we   <= a_we;
              ram_re   <= ~a_we;
              ram_addr <= a_addr;
              if (a_we) ram_din <= a_wdata;
            end else begin
              ram_we   <= b_we;
              ram_re   <= ~b_we;
              ram_addr <= b_addr;
              if (b_we) ram_din <= b_wdata;
            end
          end
        end
        ISSUE: begin
          a_gnt  <= 1'b0;
          b_gnt  <= 1'b0;
          ram_we <= 1'b0;
          ram_re <= 1'b0;
          // The grant flags still identify the owner of a read here.
          if (ram_re) begin
            state    <= RDRET;
            a_rvalid <= a_gnt;
            b_rvalid <= b_gnt;
          end else begin
            state <= IDLE;
          end
        end
        RDRET: begin
          a_rvalid <= 1'b0;
          b_rvalid <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter. Bursts of operations for A and B are
// turned into an expected grant/readback sequence by a transaction-level
// model (arbitration rule + memory array + per-operation cycle cost); a
// monitor on the falling edge pops and compares whenever the DUT shows a
// grant or an rvalid. Build with +define+SP_RAM_ARB_FIXED_PRIO_EN to
// check the fixed-priority variant.
module tb_sp_ram_arbiter;
  localparam int DATA  = 4;
  localparam int ADDR  = 2;
  localparam int DEPTH = 1 << ADDR;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            a_req, a_we, b_req, b_we;
  logic [ADDR-1:0] a_addr, b_addr;
  logic [DATA-1:0] a_wdata, b_wdata;
  logic            a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DATA-1:0] rdata;
  logic            ram_we, ram_re;
  logic [ADDR-1:0] ram_addr;
  logic [DATA-1:0] ram_din;
  logic [DATA-1:0] ram_dout;

  sp_ram_arbiter #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM the arbiter is attached to: registered read, holds dout.
  logic [DATA-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= ram_mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              we;
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] data;
  } op_t;

  typedef struct {
    int              who;   // 0 = A, 1 = B
    bit              we;
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] data;
    int              due;
  } gexp_t;

  typedef struct {
    int              who;
    logic [DATA-1:0] data;
    int              due;
  } rexp_t;

  op_t   opa[$], opb[$];
  gexp_t gq[$];
  rexp_t rq[$];

  logic [DATA-1:0] ref_mem [DEPTH];
  int  model_last;  // requester granted last: 0 = A, 1 = B
  bit  mon_en = 1'b0;
  int  vectors = 0;
  int  miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pops on grant / rvalid.
  always @(negedge clk) begin
    if (mon_en) begin
      gexp_t g;
      rexp_t r;
      chk("we_re_exclusive", {31'd0, ram_we & ram_re}, 32'd0);
      chk("strobe_only_with_gnt", {31'd0, ram_we | ram_re}, {31'd0, a_gnt | b_gnt});
      chk("one_gnt", {31'd0, a_gnt & b_gnt}, 32'd0);
      chk("one_rvalid", {31'd0, a_rvalid & b_rvalid}, 32'd0);
      if (a_gnt || b_gnt) begin
        if (gq.size() == 0) begin
          chk("spurious_gnt", {30'd0, b_gnt, a_gnt}, 32'd0);
        end else begin
          g = gq.pop_front();
          chk("gnt_who", b_gnt ? 32'd1 : 32'd0, g.who);
          chk("gnt_cycle", cyc, g.due);
          chk("ram_we", {31'd0, ram_we}, {31'd0, g.we});
          chk("ram_re", {31'd0, ram_re}, {31'd0, !g.we});
          chk("ram_addr", {30'd0, ram_addr}, {30'd0, g.addr});
          if (g.we) chk("ram_din", {28'd0, ram_din}, {28'd0, g.data});
        end
      end
      if (a_rvalid || b_rvalid) begin
        if (rq.size() == 0) begin
          chk("spurious_rvalid", {30'd0, b_rvalid, a_rvalid}, 32'd0);
        end else begin
          r = rq.pop_front();
          chk("rvalid_who", b_rvalid ? 32'd1 : 32'd0, r.who);
          chk("rvalid_cycle", cyc, r.due);
          chk("rdata", {28'd0, rdata}, {28'd0, r.data});
        end
      end
    end
  end

  function automatic op_t rand_op();
    op_t o;
    o.we   = 1'($urandom_range(0, 1));
    o.addr = ADDR'($urandom_range(0, DEPTH - 1));
    o.data = DATA'($urandom_range(0, (1 << DATA) - 1));
    return o;
  endfunction

  function automatic op_t mk(input bit we, input int addr, input int data);
    op_t o;
    o.we   = we;
    o.addr = ADDR'(addr);
    o.data = DATA'(data);
    return o;
  endfunction

  // Called at a falling edge with the DUT idle. Both requesters raise their
  // first operation together and keep requesting until their lists drain.
  task automatic run_burst();
    int na, nb, pa, pb, ia, ib, t, win, budget;
    op_t o;
    gexp_t g;
    rexp_t r;
    na = opa.size();
    nb = opb.size();
    pa = 0; pb = 0;
    t = cyc + 1;
    while (pa < na || pb < nb) begin
      if (pa < na && pb < nb) begin
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
        win = 0;
`else
        win = (model_last == 0) ? 1 : 0;
`endif
      end else begin
        win = (pa < na) ? 0 : 1;
      end
      if (win == 0) begin o = opa[pa]; pa++; end
      else          begin o = opb[pb]; pb++; end
      model_last = win;
      g.who = win; g.we = o.we; g.addr = o.addr; g.data = o.data; g.due = t;
      gq.push_back(g);
      if (o.we) begin
        ref_mem[o.addr] = o.data;
        t += 2;
      end else begin
        r.who = win; r.data = ref_mem[o.addr]; r.due = t + 1;
        rq.push_back(r);
        t += 3;
      end
    end

    ia = 0; ib = 0;
    a_req = (na > 0);
    if (na > 0) begin a_we = opa[0].we; a_addr = opa[0].addr; a_wdata = opa[0].data; end
    b_req = (nb > 0);
    if (nb > 0) begin b_we = opb[0].we; b_addr = opb[0].addr; b_wdata = opb[0].data; end
    budget = 0;
    while ((ia < na || ib < nb) && budget < 200) begin
      @(posedge clk);
      #1;
      if (a_gnt && ia < na) begin
        ia++;
        if (ia < na) begin a_we = opa[ia].we; a_addr = opa[ia].addr; a_wdata = opa[ia].data; end
        else a_req = 1'b0;
      end
      if (b_gnt && ib < nb) begin
        ib++;
        if (ib < nb) begin b_we = opb[ib].we; b_addr = opb[ib].addr; b_wdata = opb[ib].data; end
        else b_req = 1'b0;
      end
      budget++;
    end
    if (ia < na || ib < nb) begin
      chk("burst_grants", ia + ib, na + nb);
      a_req = 1'b0;
      b_req = 1'b0;
    end
    budget = 0;
    while ((gq.size() != 0 || rq.size() != 0) && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (gq.size() != 0 || rq.size() != 0) begin
      chk("drain", gq.size() + rq.size(), 0);
      gq.delete();
      rq.delete();
    end
    @(posedge clk);
    @(negedge clk);
    opa.delete();
    opb.delete();
  endtask

  initial begin
    int budget;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    ram_dout = '0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {22'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, ram_re, ram_addr, ram_din}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
    mon_en = 1'b1;
    @(negedge clk);

    // First contention after reset, then readback by A.
    opa.push_back(mk(1, 0, 3));
    opb.push_back(mk(1, 1, 5));
    run_burst();
    opa.push_back(mk(0, 0, 0));
    opa.push_back(mk(0, 1, 0));
    run_burst();

    // A alone: write addr 2 = 0xA, then read it back.
    opa.push_back(mk(1, 2, 4'hA));
    opa.push_back(mk(0, 2, 0));
    run_burst();

    // Continuous write contention, 8 grants.
    for (int i = 0; i < 4; i++) begin
      opa.push_back(mk(1, $urandom_range(0, DEPTH - 1), $urandom_range(0, 15)));
      opb.push_back(mk(1, $urandom_range(0, DEPTH - 1), $urandom_range(0, 15)));
    end
    run_burst();

    // Mixed: B reads addr 3 while A writes 0xF to it.
    opb.push_back(mk(0, 3, 0));
    opa.push_back(mk(1, 3, 4'hF));
    run_burst();

    // Long A hold against a single B request.
    for (int i = 0; i < 6; i++) opa.push_back(mk(1, i % DEPTH, i + 1));
    opb.push_back(mk(1, 2, 4'h7));
    run_burst();

    // Reset during ISSUE of an A read.
    mon_en = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 2'd1;
    budget = 0;
    do begin
      @(posedge clk);
      #1;
      budget++;
    end while (!a_gnt && budget < 10);
    chk("midread_gnt_seen", {31'd0, a_gnt}, 32'd1);
    a_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midread_reset_clear", {22'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, ram_re, ram_addr, ram_din}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midread_no_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    end
    rst_n = 1'b1;
    model_last = 1;
    mon_en = 1'b1;
    @(negedge clk);
    opa.push_back(mk(1, 1, 4'h9));
    opb.push_back(mk(1, 2, 4'h6));
    run_burst();

    // Randomized bursts.
    for (int k = 0; k < 30; k++) begin
      int na, nb;
      na = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      if (na == 0 && nb == 0) na = 1;
      for (int i = 0; i < na; i++) opa.push_back(rand_op());
      for (int i = 0; i < nb; i++) opb.push_back(rand_op());
      run_burst();
    end

    // Final readback of all addresses.
    for (int i = 0; i < DEPTH; i++) opb.push_back(mk(0, i, 0));
    run_burst();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
